// File: rtl/chunked_adder.sv
// chunked_adder: multi-cycle adder/subtractor that walks a WIDTH-bit operand
// pair CHUNK bits per clock, keeping the inter-chunk carry in a register.
//
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   start  request, sampled only in IDLE or DONE
//   sub    0 = add, 1 = subtract (latched with start)
//   a, b   operands (latched with start)
//   cin    carry-in (add) / borrow-in (sub) (latched with start)
//   out    registered result
//   cout   registered carry out of the MSB (sub: 1 = no borrow)
//   ovf    registered signed two's-complement overflow
//   busy   high while a chunk walk is in progress
//   done   one-cycle pulse when a new result is valid
module chunked_adder #(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] out,
  output logic             cout,
  output logic             ovf,
  output logic             busy,
  output logic             done
);

  localparam int NCH = WIDTH / CHUNK;
  // Keep the counter at least one bit wide so CHUNK == WIDTH still elaborates.
  localparam int CW  = (NCH > 1) ? $clog2(NCH) : 1;
  localparam logic [CW-1:0] LAST = CW'(NCH - 1);

  generate
    if ((CHUNK < 1) || (CHUNK > WIDTH) || ((WIDTH % CHUNK) != 0)) begin : g_bad_param
      $error("chunked_adder: WIDTH must be a positive multiple of CHUNK");
    end
  endgenerate

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t state, state_nx;

  logic [WIDTH-1:0] a_r, b_r, sum_r, sum_nx;
  logic             carry;
  logic [CW-1:0]    cnt;
  logic             accept;
  logic             last;

  // Chunk datapath
  int               base;
  logic [CHUNK-1:0] a_c, b_c;
  logic [CHUNK:0]   c_sum;
  logic             msb_cin;

  assign accept = start && ((state == S_IDLE) || (state == S_DONE));
  assign last   = (cnt == LAST);

  // ---------------------------------------------------------------------------
  // FSM: state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nx;
  end

  // FSM: next state
  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:  if (start) state_nx = S_RUN;
      S_RUN:   if (last)  state_nx = S_DONE;
      S_DONE:  state_nx = start ? S_RUN : S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    case (state)
      S_RUN:   busy = 1'b1;
      S_DONE:  done = 1'b1;
      default: ;
    endcase
  end

  // ---------------------------------------------------------------------------
  // One chunk of the ripple: only a CHUNK-bit carry chain lives in a cycle.
  always_comb begin
    base   = int'(cnt) * CHUNK;
    a_c    = a_r[base +: CHUNK];
    b_c    = b_r[base +: CHUNK];
    c_sum  = {1'b0, a_c} + {1'b0, b_c} + {{CHUNK{1'b0}}, carry};
    sum_nx = sum_r;
    sum_nx[base +: CHUNK] = c_sum[CHUNK-1:0];
    // Carry into the MSB recovered from its sum bit; only meaningful on the
    // final chunk, which is the only time it is used.
    msb_cin = a_r[WIDTH-1] ^ b_r[WIDTH-1] ^ sum_nx[WIDTH-1];
  end

  // ---------------------------------------------------------------------------
  // Operand / carry / counter registers. Subtract is folded in at accept time
  // (b inverted, carry seeded with ~cin) so the walk itself is always an add.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_r   <= '0;
      b_r   <= '0;
      sum_r <= '0;
      carry <= 1'b0;
      cnt   <= '0;
    end else if (accept) begin
      a_r   <= a;
      b_r   <= sub ? ~b : b;
      sum_r <= '0;
      carry <= cin ^ sub;
      cnt   <= '0;
    end else if (state == S_RUN) begin
      sum_r <= sum_nx;
      carry <= c_sum[CHUNK];
      if (!last) cnt <= cnt + CW'(1);
    end
  end

  // Result registers move only on the RUN->DONE edge and otherwise hold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out  <= '0;
      cout <= 1'b0;
      ovf  <= 1'b0;
    end else if ((state == S_RUN) && last) begin
      out  <= sum_nx;
      cout <= c_sum[CHUNK];
      ovf  <= msb_cin ^ c_sum[CHUNK];
    end
  end

endmodule

// File: tb/tb_chunked_adder.sv
// Directed bench for chunked_adder: hand-computed vectors on the 32/8 build,
// handshake and async-reset cases, plus a reference-model sweep across the
// 32/8, 32/1, 32/32 and 8/4 builds.
module tb_chunked_adder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0, sub = 1'b0, cin = 1'b0;
  logic [31:0] a = '0, b = '0;
  logic [31:0] out;
  logic        cout, ovf, busy, done;

  // Sweep stimulus shared by the alternative builds
  logic        s_start = 1'b0, s_sub = 1'b0, s_cin = 1'b0;
  logic [31:0] s_a = '0, s_b = '0;
  logic [31:0] o_c1, o_c32;
  logic [7:0]  o_w8;
  logic        co_c1, co_c32, co_w8, ov_c1, ov_c32, ov_w8;
  logic        bz_c1, bz_c32, bz_w8, dn_c1, dn_c32, dn_w8;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  chunked_adder #(.WIDTH(32), .CHUNK(8)) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .sub(sub), .a(a), .b(b), .cin(cin),
    .out(out), .cout(cout), .ovf(ovf), .busy(busy), .done(done));

  chunked_adder #(.WIDTH(32), .CHUNK(1)) u_c1 (
    .clk(clk), .rst_n(rst_n), .start(s_start), .sub(s_sub), .a(s_a), .b(s_b), .cin(s_cin),
    .out(o_c1), .cout(co_c1), .ovf(ov_c1), .busy(bz_c1), .done(dn_c1));

  chunked_adder #(.WIDTH(32), .CHUNK(32)) u_c32 (
    .clk(clk), .rst_n(rst_n), .start(s_start), .sub(s_sub), .a(s_a), .b(s_b), .cin(s_cin),
    .out(o_c32), .cout(co_c32), .ovf(ov_c32), .busy(bz_c32), .done(dn_c32));

  chunked_adder #(.WIDTH(8), .CHUNK(4)) u_w8 (
    .clk(clk), .rst_n(rst_n), .start(s_start), .sub(s_sub), .a(s_a[7:0]), .b(s_b[7:0]),
    .cin(s_cin), .out(o_w8), .cout(co_w8), .ovf(ov_w8), .busy(bz_w8), .done(dn_w8));

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", tag, obs, exp);
    end
  endtask

  // Whole-width reference: {ovf, cout, out} for a w-bit operation.
  function automatic logic [33:0] ref_op(input logic [31:0] ra, input logic [31:0] rb,
                                         input logic rc, input logic rs, input int w);
    logic [31:0] mask;
    logic [32:0] bb, s;
    logic        sa, sb, sr;
    mask = (w == 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
    bb   = {1'b0, (rs ? ~rb : rb) & mask};
    s    = {1'b0, ra & mask} + bb + {32'd0, rc ^ rs};
    sa   = ra[w-1];
    sb   = bb[w-1];
    sr   = s[w-1];
    return {((sa == sb) && (sr != sa)), s[w], s[31:0] & mask};
  endfunction

  // Count negedges until done (the current one is 1), bounded.
  task automatic wait_done(output int lat);
    lat = 1;
    while (!done && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    chk("done_seen", {63'd0, done}, 64'd1);
  endtask

  task automatic run_op(input string tag, input logic [31:0] ta, input logic [31:0] tb,
                        input logic tc, input logic ts, input logic [31:0] e_out,
                        input logic e_co, input logic e_ov);
    int lat;
    @(negedge clk);
    a = ta; b = tb; cin = tc; sub = ts; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk({tag, ".busy"}, {63'd0, busy}, 64'd1);
    wait_done(lat);
    chk({tag, ".lat"}, 64'(lat), 64'd5);
    chk({tag, ".out"}, {32'd0, out}, {32'd0, e_out});
    chk({tag, ".cout"}, {63'd0, cout}, {63'd0, e_co});
    chk({tag, ".ovf"}, {63'd0, ovf}, {63'd0, e_ov});
    @(negedge clk);
    chk({tag, ".done1"}, {62'd0, done, busy}, 64'd0);
  endtask

  initial begin
    int  lat, busy_n;
    bit  seen;
    logic [33:0] r;

    // Reset state
    #12;
    @(negedge clk);
    chk("rst", {29'd0, out, cout, ovf, busy, done}, 64'd0);
    rst_n = 1'b1;

    // First op: busy exactly 4 cycles, done on the 5th
    @(negedge clk);
    a = 32'h1; b = 32'h1; cin = 1'b0; sub = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    busy_n = 0;
    lat = 1;
    while (!done && lat < 40) begin
      if (busy) busy_n++;
      @(negedge clk);
      lat++;
    end
    chk("first.busy_n", 64'(busy_n), 64'd4);
    chk("first.lat", 64'(lat), 64'd5);
    chk("first.out", {32'd0, out}, 64'h2);
    chk("first.flags", {62'd0, cout, ovf}, 64'd0);
    @(negedge clk);
    chk("first.pulse", {63'd0, done}, 64'd0);

    run_op("ripple", 32'hFFFF_FFFF, 32'h1, 1'b0, 1'b0, 32'h0,         1'b1, 1'b0);
    run_op("sovf",   32'h7FFF_FFFF, 32'h1, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1);
    run_op("cin",    32'h0000_00FF, 32'h0, 1'b1, 1'b0, 32'h100,       1'b0, 1'b0);
    run_op("sub5_7", 32'd5, 32'd7,         1'b0, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0);
    run_op("sub7_5", 32'd7, 32'd5,         1'b0, 1'b1, 32'h2,         1'b1, 1'b0);
    run_op("subovf", 32'h8000_0000, 32'h1, 1'b0, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1);
    run_op("borrow", 32'd7, 32'd5,         1'b1, 1'b1, 32'h1,         1'b1, 1'b0);
    run_op("pre",    32'd3, 32'd4,         1'b0, 1'b0, 32'd7,         1'b0, 1'b0);

    // start during RUN is ignored; out holds the previous result meanwhile
    @(negedge clk);
    a = 32'h10; b = 32'h20; cin = 1'b0; sub = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    a = 32'hAAAA_AAAA; b = 32'h1234_5678; sub = 1'b1; start = 1'b1;
    chk("hold.run", {32'd0, out}, 64'd7);
    @(negedge clk);
    start = 1'b0;
    lat = 1;
    while (!done && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    chk("ign.done", {63'd0, done}, 64'd1);
    chk("ign.out", {32'd0, out}, 64'h30);

    // start held into DONE: accepted back-to-back with no IDLE cycle
    a = 32'h100; b = 32'h1; cin = 1'b1; sub = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("b2b.state", {62'd0, busy, done}, 64'd2);
    chk("b2b.hold", {32'd0, out}, 64'h30);
    wait_done(lat);
    chk("b2b.lat", 64'(lat), 64'd5);
    chk("b2b.out", {32'd0, out}, 64'h102);

    // Async reset mid-operation at cnt==2
    run_op("prerst", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0, 32'hFFFF_FFFE, 1'b1, 1'b0);
    @(negedge clk);
    a = 32'h11; b = 32'h22; cin = 1'b0; sub = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1 chk("arst", {29'd0, out, cout, ovf, busy, done}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (8) begin
      @(negedge clk);
      if (done || busy) seen = 1'b1;
    end
    chk("arst.quiet", {63'd0, seen}, 64'd0);
    run_op("postrst", 32'h11, 32'h22, 1'b0, 1'b0, 32'h33, 1'b0, 1'b0);

    // Sweep on the 32/8 build against the reference model
    for (int i = 0; i < 87; i++) begin
      logic [31:0] iv;
      iv = 32'(i);
      r  = ref_op(iv, iv + 32'd1, iv[0], iv[1], 32);
      run_op($sformatf("sw8_%0d", i), iv, iv + 32'd1, iv[0], iv[1], r[31:0], r[32], r[33]);
    end

    // Sweep on the 32/1, 32/32 and 8/4 builds, run side by side
    for (int i = 0; i < 87; i++) begin
      logic [31:0] iv;
      logic [33:0] r1, r8;
      int l1, l32, l8;
      logic [31:0] g1, g32;
      logic [7:0]  g8;
      logic [1:0]  f1, f32, f8;
      iv = 32'(i);
      r1 = ref_op(iv, iv + 32'd1, iv[0], iv[1], 32);
      r8 = ref_op(iv, iv + 32'd1, iv[0], iv[1], 8);
      l1 = 0; l32 = 0; l8 = 0;
      g1 = '0; g32 = '0; g8 = '0; f1 = '0; f32 = '0; f8 = '0;
      @(negedge clk);
      s_a = iv; s_b = iv + 32'd1; s_cin = iv[0]; s_sub = iv[1]; s_start = 1'b1;
      @(negedge clk);
      s_start = 1'b0;
      for (int c = 1; c <= 40; c++) begin
        if (dn_c1  && l1  == 0) begin l1  = c; g1  = o_c1;  f1  = {co_c1,  ov_c1};  end
        if (dn_c32 && l32 == 0) begin l32 = c; g32 = o_c32; f32 = {co_c32, ov_c32}; end
        if (dn_w8  && l8  == 0) begin l8  = c; g8  = o_w8;  f8  = {co_w8,  ov_w8};  end
        @(negedge clk);
      end
      chk($sformatf("c1_%0d.lat", i),  64'(l1),  64'd33);
      chk($sformatf("c32_%0d.lat", i), 64'(l32), 64'd2);
      chk($sformatf("w8_%0d.lat", i),  64'(l8),  64'd3);
      chk($sformatf("c1_%0d.res", i),  {30'd0, f1,  g1},  {30'd0, r1[32], r1[33], r1[31:0]});
      chk($sformatf("c32_%0d.res", i), {30'd0, f32, g32}, {30'd0, r1[32], r1[33], r1[31:0]});
      chk($sformatf("w8_%0d.res", i),  {54'd0, f8,  g8},  {54'd0, r8[32], r8[33], r8[7:0]});
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
